// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS32 control sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// with memory wait-state stalls and a sticky trap on memory timeout or illegal opcode.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_b,
    output logic [1:0] aluop,
    output logic       reg_write,
    output logic       reg_write2,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       lui,
    output logic       jal,
    output logic       retire,
    output logic       trap,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_WB2    = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           st;
    state_t           st_nxt;
    logic [5:0]       op_q;
    logic [5:0]       op_cur;
    logic [CNT_W-1:0] cnt;
    logic             at_limit;
    logic             is_rtype, is_lw, is_sw, is_beq, is_bne, is_ori, is_j, is_jal, is_lui;
    logic             is_illegal;

    // The IR is loaded at the end of FETCH, so DECODE sees the live opcode; later states use the latch.
    assign op_cur     = (st == S_DECODE) ? opcode : op_q;
    assign is_rtype   = (op_cur == OP_RTYPE);
    assign is_lw      = (op_cur == OP_LW);
    assign is_sw      = (op_cur == OP_SW);
    assign is_beq     = (op_cur == OP_BEQ);
    assign is_bne     = (op_cur == OP_BNE);
    assign is_ori     = (op_cur == OP_ORI);
    assign is_j       = (op_cur == OP_J);
    assign is_jal     = (op_cur == OP_JAL);
    assign is_lui     = (op_cur == OP_LUI);
    assign is_illegal = !(is_rtype || is_lw || is_sw || is_beq || is_bne ||
                          is_ori || is_j || is_jal || is_lui);
    assign at_limit   = (cnt == CNT_LIMIT);

    // Memory handshake: mem_req is held until the cycle mem_ready=1; that cycle completes the
    // access. mem_ready in any cycle without mem_req is ignored.
    always_comb begin
        st_nxt = st;
        case (st)
            S_FETCH:  if (mem_ready)     st_nxt = S_DECODE;
                      else if (at_limit) st_nxt = S_TRAP;
            S_DECODE: if (is_illegal)           st_nxt = S_TRAP;
                      else if (is_j || is_jal)  st_nxt = S_FETCH;
                      else                      st_nxt = S_EXEC;
            S_EXEC:   if (is_rtype || is_ori || is_lui) st_nxt = S_WB;
                      else if (is_lw || is_sw)          st_nxt = S_MEM;
                      else if (is_beq || is_bne)        st_nxt = S_FETCH;
                      else                              st_nxt = S_TRAP;
            S_MEM:    if (mem_ready)     st_nxt = is_sw ? S_FETCH : S_WB;
                      else if (at_limit) st_nxt = S_TRAP;
            S_WB:     st_nxt = is_rtype ? S_WB2 : S_FETCH;
            S_WB2:    st_nxt = S_FETCH;
            S_TRAP:   st_nxt = S_TRAP;
            default:  st_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st   <= S_FETCH;
            op_q <= '0;
            cnt  <= '0;
        end else begin
            st <= st_nxt;
            if (st == S_DECODE) op_q <= opcode;
            // Counter restarts on any state change, so entering FETCH/MEM always begins at zero.
            if (mem_ready || (st_nxt != st)) begin
                cnt <= '0;
            end else if (((st == S_FETCH) || (st == S_MEM)) && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_b  = 1'b0;
        aluop      = 2'b00;
        reg_write  = 1'b0;
        reg_write2 = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        lui        = 1'b0;
        jal        = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        state      = reset ? 3'd0 : 3'(st);
        if (!reset) begin
            case (st)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (is_j || is_jal) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        retire   = 1'b1;
                        reg_write = is_jal;
                        jal       = is_jal;
                    end
                end
                S_EXEC: begin
                    if (is_rtype) begin
                        aluop = 2'b10;
                    end else if (is_ori) begin
                        aluop     = 2'b11;
                        alu_src_b = 1'b1;
                    end else if (is_lui || is_lw || is_sw) begin
                        alu_src_b = 1'b1;
                    end else if (is_beq || is_bne) begin
                        aluop    = 2'b01;
                        pc_src   = 2'b01;
                        pc_write = is_beq ? zero : ~zero;
                        retire   = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    alu_src_b = 1'b1;
                    mem_we    = is_sw;
                    retire    = mem_ready && is_sw;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = is_rtype;
                    mem_to_reg = is_lw;
                    lui        = is_lui;
                    alu_src_b  = is_ori || is_lui || is_lw;
                    aluop      = is_rtype ? 2'b10 : (is_ori ? 2'b11 : 2'b00);
                    retire     = !is_rtype;
                end
                S_WB2: begin
                    reg_write2 = 1'b1;
                    reg_dst    = 1'b1;
                    aluop      = 2'b10;
                    retire     = 1'b1;
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: a per-instruction cycle schedule built from the instruction
// classes is compared against the full output bundle every cycle.
module tb_multicycle_sequencer;

    localparam int T = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       trap, retire, jal, lui, m2r, reg_dst, rw2, rw;
        logic [1:0] aluop;
        logic       asb;
        logic [1:0] pc_src;
        logic       pc_write, ir_write, iord, mem_we, mem_req;
    } ov_t;

    localparam int C_RT = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_BNE = 4;
    localparam int C_ORI = 5, C_J = 6, C_JAL = 7, C_LUI = 8, C_ILL = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_b;
    logic [1:0] pc_src, aluop;
    logic       reg_write, reg_write2, reg_dst, mem_to_reg, lui, jal, retire, trap;
    logic [2:0] state;
    logic [20:0] act;

    logic        rst_q[$];
    logic        rdy_q[$];
    logic [20:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    string       cur_tag;
    logic [5:0]  cur_op;
    logic        cur_z;

    multicycle_sequencer #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b), .aluop(aluop),
        .reg_write(reg_write), .reg_write2(reg_write2), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .lui(lui), .jal(jal), .retire(retire), .trap(trap),
        .state(state)
    );

    always #5 clk = ~clk;

    assign act = {state, trap, retire, jal, lui, mem_to_reg, reg_dst, reg_write2, reg_write,
                  aluop, alu_src_b, pc_src, pc_write, ir_write, iord, mem_we, mem_req};

    task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                     tag, got, exp, got[20:18], exp[20:18]);
        end
    endtask

    function automatic int cls(input logic [5:0] op);
        case (op)
            6'b000000: return C_RT;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000101: return C_BNE;
            6'b001101: return C_ORI;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            6'b001111: return C_LUI;
            default:   return C_ILL;
        endcase
    endfunction

    task automatic push(input logic r, input logic rdy, input ov_t v);
        rst_q.push_back(r);
        rdy_q.push_back(rdy);
        exp_q.push_back(v);
    endtask

    // One memory access of w wait states; traps once T cycles pass without mem_ready.
    task automatic access(input logic [2:0] st, input int w, input int c, inout bit trapped);
        ov_t v;
        for (int k = 0; k <= w && !trapped; k++) begin
            v = '0;
            v.st = st;
            v.mem_req = 1'b1;
            if (st == 3'd3) begin
                v.iord = 1'b1;
                v.asb = 1'b1;
                v.mem_we = (c == C_SW);
            end
            if (k < w) begin
                push(1'b0, 1'b0, v);
                if (k == T - 1) trapped = 1;
            end else begin
                if (st == 3'd0) begin
                    v.ir_write = 1'b1;
                    v.pc_write = 1'b1;
                end else begin
                    v.retire = (c == C_SW);
                end
                push(1'b0, 1'b1, v);
            end
        end
    endtask

    task automatic plan_instr(input string tag, input logic [5:0] op, input logic z,
                              input int wf, input int wm, input int abort_at);
        int  c = cls(op);
        int  start = exp_q.size();
        bit  trapped = 0;
        ov_t v;
        cur_tag = tag;
        cur_op = op;
        cur_z = z;
        access(3'd0, wf, c, trapped);
        if (!trapped) begin
            v = '0;
            v.st = 3'd1;
            if (c == C_ILL) trapped = 1;
            if (c == C_J || c == C_JAL) begin
                v.pc_write = 1'b1;
                v.pc_src = 2'b10;
                v.retire = 1'b1;
                v.rw = (c == C_JAL);
                v.jal = (c == C_JAL);
            end
            push(1'b0, 1'($urandom_range(0, 1)), v);
        end
        if (!trapped && c != C_ILL && c != C_J && c != C_JAL) begin
            v = '0;
            v.st = 3'd2;
            case (c)
                C_RT:  v.aluop = 2'b10;
                C_ORI: begin v.aluop = 2'b11; v.asb = 1'b1; end
                C_BEQ, C_BNE: begin
                    v.aluop = 2'b01;
                    v.pc_src = 2'b01;
                    v.pc_write = (c == C_BEQ) ? z : !z;
                    v.retire = 1'b1;
                end
                default: v.asb = 1'b1;
            endcase
            push(1'b0, 1'($urandom_range(0, 1)), v);
            if (c == C_LW || c == C_SW) access(3'd3, wm, c, trapped);
            if (!trapped && (c == C_RT || c == C_ORI || c == C_LUI || c == C_LW)) begin
                v = '0;
                v.st = 3'd4;
                v.rw = 1'b1;
                v.reg_dst = (c == C_RT);
                v.m2r = (c == C_LW);
                v.lui = (c == C_LUI);
                v.asb = (c != C_RT);
                v.aluop = (c == C_RT) ? 2'b10 : ((c == C_ORI) ? 2'b11 : 2'b00);
                v.retire = (c != C_RT);
                push(1'b0, 1'($urandom_range(0, 1)), v);
                if (c == C_RT) begin
                    v = '0;
                    v.st = 3'd5;
                    v.rw2 = 1'b1;
                    v.reg_dst = 1'b1;
                    v.aluop = 2'b10;
                    v.retire = 1'b1;
                    push(1'b0, 1'($urandom_range(0, 1)), v);
                end
            end
        end
        if (abort_at >= 0 && exp_q.size() - start > abort_at) begin
            while (exp_q.size() > start + abort_at) begin
                void'(exp_q.pop_back());
                void'(rst_q.pop_back());
                void'(rdy_q.pop_back());
            end
            push(1'b1, 1'($urandom_range(0, 1)), '0);
        end else if (trapped) begin
            v = '0;
            v.st = 3'd6;
            v.trap = 1'b1;
            for (int i = 0; i < 3; i++) push(1'b0, 1'($urandom_range(0, 1)), v);
            push(1'b1, 1'b0, '0);
        end
    endtask

    task automatic drain();
        logic [20:0] e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            opcode = cur_op;
            zero = cur_z;
            reset = rst_q.pop_front();
            mem_ready = rdy_q.pop_front();
            e = exp_q.pop_front();
            #1;
            check_eq(cur_tag, act, e);
        end
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic z,
                       input int wf, input int wm, input int abort_at);
        plan_instr(tag, op, z, wf, wm, abort_at);
        drain();
    endtask

    logic [5:0] legal_ops[9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                 6'b001101, 6'b000010, 6'b000011, 6'b001111};
    logic [5:0] bad_ops[3] = '{6'b111111, 6'b000001, 6'b100000};

    initial begin
        cur_tag = "reset";
        cur_op = '0;
        cur_z = 1'b0;
        push(1'b1, 1'b0, '0);
        push(1'b1, 1'b1, '0);
        drain();

        run("rtype",        6'b000000, 1'b0, 0, 0, -1);
        run("lw_wait3",     6'b100011, 1'b0, 0, 3, -1);
        run("beq_z1",       6'b000100, 1'b1, 0, 0, -1);
        run("bne_z1",       6'b000101, 1'b1, 0, 0, -1);
        run("beq_z0",       6'b000100, 1'b0, 1, 0, -1);
        run("jal",          6'b000011, 1'b0, 0, 0, -1);
        run("j",            6'b000010, 1'b0, 2, 0, -1);
        run("sw",           6'b101011, 1'b0, 0, 0, -1);
        run("fetch_tmo",    6'b000000, 1'b0, T, 0, -1);
        run("fetch_edge",   6'b000000, 1'b0, T - 1, 0, -1);
        run("mem_tmo",      6'b101011, 1'b0, 0, T + 2, -1);
        run("mem_edge",     6'b100011, 1'b0, 0, T - 1, -1);
        run("illegal",      6'b111111, 1'b0, 0, 0, -1);
        run("ori_abort_wb", 6'b001101, 1'b0, 0, 0, 3);
        run("lui",          6'b001111, 1'b0, 0, 0, -1);

        for (int i = 0; i < 200; i++) begin
            logic [5:0] op;
            int wf, wm, ab;
            op = ($urandom_range(0, 9) == 0) ? bad_ops[$urandom_range(0, 2)]
                                             : legal_ops[$urandom_range(0, 8)];
            wf = ($urandom_range(0, 11) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, T - 1);
            wm = ($urandom_range(0, 11) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, T - 1);
            ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 6) : -1;
            run("random", op, 1'($urandom_range(0, 1)), wf, wm, ab);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
